// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator sequencer.
//   - eBCD key codes (digits are 0..9, commands A..F)
//   - operator encodings driven to the calculate datapath
//   - sequencer state encoding
//   - ERR_CODE shown on the display while in ERROR
//   - calc_req_t: the operand/operator bundle handed to calculate
package calc_pkg;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_MUL  = 4'hC;
  localparam logic [3:0] KEY_DIV  = 4'hD;
  localparam logic [3:0] KEY_EQ   = 4'hE;
  localparam logic [3:0] KEY_SIGN = 4'hF;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_NONE = 3'd4;

  localparam logic signed [31:0] ERR_CODE = 32'sh8000_0000;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_CALC,
    ST_SHOW,
    ST_ERROR
  } state_e;

  typedef struct packed {
    logic signed [31:0] op1;
    logic signed [31:0] op2;
    logic [2:0]         opr;
  } calc_req_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys A..D map to encodings 0..3.
  function automatic logic [2:0] key_to_op(input logic [3:0] k);
    logic [2:0] r;
    case (k)
      KEY_ADD: r = OP_ADD;
      KEY_SUB: r = OP_SUB;
      KEY_MUL: r = OP_MUL;
      KEY_DIV: r = OP_DIV;
      default: r = OP_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/entry_buffer.sv
// entry_buffer: operand entry register for the calculator.
// Holds a sign bit and a 31-bit magnitude, accumulates decimal digits up to
// MAX_DIGITS (further digits are dropped) and presents a signed value.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr_i         clear sign/magnitude/count (may combine with digit_en_i,
//                 in which case the digit becomes the first of a new entry)
//   digit_en_i    append digit_i
//   digit_i       decimal digit 0..9
//   sign_tgl_i    toggle the sign
//   value_o       signed value of the buffer (-0 reads as 0)
module entry_buffer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               digit_en_i,
  input  logic [3:0]         digit_i,
  input  logic               sign_tgl_i,
  output logic signed [31:0] value_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  logic [30:0]      mag_q, mag_d, mag_base;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  always_comb begin
    // Clear is applied first so a clear+digit starts a fresh one-digit entry.
    mag_base = clr_i ? '0 : mag_q;
    cnt_base = clr_i ? '0 : cnt_q;
    mag_d    = mag_base;
    cnt_d    = cnt_base;
    sign_d   = clr_i ? 1'b0 : sign_q;
    if (digit_en_i && (cnt_base < MAX_CNT)) begin
      mag_d = (mag_base * 31'd10) + 31'(digit_i);
      cnt_d = cnt_base + 1'b1;
    end
    if (sign_tgl_i) sign_d = ~sign_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mag_q  <= mag_d;
      sign_q <= sign_d;
      cnt_q  <= cnt_d;
    end
  end

  assign value_o = sign_q ? -$signed({1'b0, mag_q}) : $signed({1'b0, mag_q});

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: central controller of the keypad calculator.
// Collects eBCD keys into two signed operands and an operator, fires a
// one-cycle calc_start into the calculate datapath, waits for done/error or a
// timeout, and drives the display value.
// Optional build macro: CALC_CHAIN_EN -- an operator key while showing a
// result reuses that result as operand1 and continues with operand2 entry.
// Without it, operator keys in SHOW are ignored.
// Ports:
//   sw_clk, rst          clock, synchronous active-high reset
//   key_valid, eBCD      key strobe and key code
//   ans, calc_done,      result handshake from calculate
//   calc_error
//   operand1, operand2,  request to calculate (stable throughout CALC)
//   operator, calc_start
//   fnd_serial           signed display value
//   err                  high while in ERROR
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS   = 4,
  parameter int CALC_TIMEOUT = 64
) (
  input  logic               sw_clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         eBCD,
  input  logic signed [31:0] ans,
  input  logic               calc_done,
  input  logic               calc_error,
  output logic signed [31:0] operand1,
  output logic signed [31:0] operand2,
  output logic [2:0]         operator,
  output logic               calc_start,
  output logic signed [31:0] fnd_serial,
  output logic               err
);

  localparam int TMO_W = $clog2(CALC_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CALC_TIMEOUT - 1);

  state_e             state_q, state_d;
  calc_req_t          req_q, req_d;
  logic               start_q, start_d;
  logic signed [31:0] res_q, res_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               buf_clr, buf_dig, buf_sgn;
  logic signed [31:0] buf_val;

  logic key_dig, key_op, key_eq, key_sgn;
  assign key_dig = key_valid && is_digit(eBCD);
  assign key_op  = key_valid && is_op(eBCD);
  assign key_eq  = key_valid && (eBCD == KEY_EQ);
  assign key_sgn = key_valid && (eBCD == KEY_SIGN);

  entry_buffer #(.MAX_DIGITS(MAX_DIGITS)) u_buf (
    .clk        (sw_clk),
    .rst        (rst),
    .clr_i      (buf_clr),
    .digit_en_i (buf_dig),
    .digit_i    (eBCD),
    .sign_tgl_i (buf_sgn),
    .value_o    (buf_val)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    start_d = 1'b0;
    res_d   = res_q;
    tmo_d   = tmo_q;
    buf_clr = 1'b0;
    buf_dig = 1'b0;
    buf_sgn = 1'b0;

    case (state_q)
      ST_ENTER_A: begin
        buf_dig = key_dig;
        buf_sgn = key_sgn;
        if (key_op) begin
          req_d.op1 = buf_val;
          req_d.opr = key_to_op(eBCD);
          buf_clr   = 1'b1;
          state_d   = ST_ENTER_B;
        end
      end

      ST_ENTER_B: begin
        buf_dig = key_dig;
        buf_sgn = key_sgn;
        if (key_op) req_d.opr = key_to_op(eBCD);
        if (key_eq) begin
          req_d.op2 = buf_val;
          start_d   = 1'b1;
          tmo_d     = '0;
          state_d   = ST_CALC;
        end
      end

      // Keys are not looked at here; a key coinciding with done is dropped.
      ST_CALC: begin
        if (calc_done) begin
          if (calc_error) begin
            state_d = ST_ERROR;
          end else begin
            res_d   = ans;
            state_d = ST_SHOW;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_SHOW: begin
        if (key_dig) begin
          buf_clr = 1'b1;
          buf_dig = 1'b1;
          state_d = ST_ENTER_A;
        end else if (key_sgn) begin
          buf_clr   = 1'b1;
          req_d.op1 = '0;
          req_d.op2 = '0;
          req_d.opr = OP_NONE;
          res_d     = '0;
          state_d   = ST_ENTER_A;
        end else if (key_op) begin
`ifdef CALC_CHAIN_EN
          req_d.op1 = res_q;
          req_d.opr = key_to_op(eBCD);
          buf_clr   = 1'b1;
          state_d   = ST_ENTER_B;
`endif
        end
      end

      ST_ERROR: begin
        if (key_dig || key_sgn) begin
          buf_clr   = 1'b1;
          buf_dig   = key_dig;
          req_d.op1 = '0;
          req_d.op2 = '0;
          req_d.opr = OP_NONE;
          res_d     = '0;
          state_d   = ST_ENTER_A;
        end
      end

      default: state_d = ST_ENTER_A;
    endcase
  end

  always_ff @(posedge sw_clk) begin
    if (rst) begin
      state_q   <= ST_ENTER_A;
      req_q.op1 <= '0;
      req_q.op2 <= '0;
      req_q.opr <= OP_NONE;
      start_q   <= 1'b0;
      res_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      start_q <= start_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_SHOW:  fnd_serial = res_q;
      ST_ERROR: fnd_serial = ERR_CODE;
      default:  fnd_serial = buf_val;
    endcase
  end

  assign operand1   = req_q.op1;
  assign operand2   = req_q.op2;
  assign operator   = req_q.opr;
  assign calc_start = start_q;
  assign err        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int MAXD = 4;

  logic               sw_clk = 1'b0;
  logic               rst = 1'b1;
  logic               key_valid = 1'b0;
  logic [3:0]         eBCD = 4'd0;
  logic signed [31:0] ans = '0;
  logic               calc_done = 1'b0;
  logic               calc_error = 1'b0;
  logic signed [31:0] operand1, operand2, fnd_serial;
  logic [2:0]         operator;
  logic               calc_start, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int op;
  } exp_t;
  exp_t exp_q[$];

  always #5 sw_clk = ~sw_clk;

  calc_sequencer #(.MAX_DIGITS(MAXD), .CALC_TIMEOUT(64)) dut (
    .sw_clk     (sw_clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .eBCD       (eBCD),
    .ans        (ans),
    .calc_done  (calc_done),
    .calc_error (calc_error),
    .operand1   (operand1),
    .operand2   (operand2),
    .operator   (operator),
    .calc_start (calc_start),
    .fnd_serial (fnd_serial),
    .err        (err)
  );

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every calc_start pops one expected request.
  logic prev_start = 1'b0;
  exp_t m_e;
  always @(negedge sw_clk) begin
    if (calc_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL start_unexpected: got op1=%0d op2=%0d opr=%0d expected no start",
                 operand1, operand2, operator);
      end else begin
        m_e = exp_q.pop_front();
        chk("start_op1", operand1, m_e.a);
        chk("start_op2", operand2, m_e.b);
        chk("start_opr", operator, m_e.op);
      end
      chk("start_width", prev_start, 0);
    end
    prev_start <= calc_start;
  end

  task automatic press(input logic [3:0] k);
    @(negedge sw_clk);
    key_valid = 1'b1;
    eBCD = k;
    @(negedge sw_clk);
    key_valid = 1'b0;
  endtask

  task automatic press_num(input int v);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) press(4'(s[i] - "0"));
  endtask

  task automatic do_reset();
    @(negedge sw_clk);
    rst = 1'b1;
    @(negedge sw_clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; done is seen on the next rising edge.
  task automatic done(input int a, input bit e);
    calc_done = 1'b1;
    ans = a;
    calc_error = e;
    @(negedge sw_clk);
    calc_done = 1'b0;
    calc_error = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op1"}, operand1, 0);
    chk({tag, "_op2"}, operand2, 0);
    chk({tag, "_opr"}, operator, OP_NONE);
    chk({tag, "_start"}, calc_start, 0);
    chk({tag, "_fnd"}, fnd_serial, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Reference arithmetic of the calculate block.
  task automatic ref_calc(input int a, input int b, input int op,
                          output int r, output bit e);
    longint x;
    e = 1'b0;
    x = 0;
    case (op)
      0: x = longint'(a) + longint'(b);
      1: x = longint'(a) - longint'(b);
      2: x = longint'(a) * longint'(b);
      default: if (b == 0) e = 1'b1; else x = longint'(a / b);
    endcase
    if (x > 64'sd2147483647 || x < -64'sd2147483648) e = 1'b1;
    r = int'(x);
  endtask

  // Enter random digits (possibly more than MAXD) and sign toggles;
  // returns the signed value the entry should represent.
  task automatic rand_operand(output int v);
    int n, mag, d;
    bit neg;
    n = $urandom_range(1, 6);
    mag = 0;
    for (int i = 0; i < n; i++) begin
      d = $urandom_range(0, 9);
      press(4'(d));
      if (i < MAXD) mag = mag * 10 + d;
    end
    neg = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      press(KEY_SIGN);
      neg = !neg;
    end
    v = neg ? -mag : mag;
  endtask

  task automatic rand_round();
    int a, b, op, r, lat;
    bit e, tmo;
    if ($urandom_range(0, 3) == 0) press(KEY_EQ);
    rand_operand(a);
    chk("entry_a", fnd_serial, a);
    op = $urandom_range(0, 3);
    press(4'(10 + op));
    chk("clear_after_op", fnd_serial, 0);
    if ($urandom_range(0, 2) == 0) begin
      op = $urandom_range(0, 3);
      press(4'(10 + op));
    end
    rand_operand(b);
    chk("entry_b", fnd_serial, b);
    ref_calc(a, b, op, r, e);
    if ($urandom_range(0, 7) == 0) e = 1'b1;
    tmo = ($urandom_range(0, 9) == 0);
    exp_q.push_back('{a, b, op});
    press(KEY_EQ);
    chk("start_pulse", calc_start, 1);
    if (tmo) begin
      repeat (64) @(negedge sw_clk);
      chk("rand_tmo_err", err, 1);
      chk("rand_tmo_fnd", fnd_serial, ERR_CODE);
    end else begin
      lat = $urandom_range(0, 10);
      repeat (lat) @(negedge sw_clk);
      if ($urandom_range(0, 1) == 1) begin
        key_valid = 1'b1;
        eBCD = 4'($urandom_range(0, 15));
      end
      done(r, e);
      key_valid = 1'b0;
      chk("rand_err", err, e);
      chk("rand_fnd", fnd_serial, e ? longint'(ERR_CODE) : longint'(r));
    end
    press(KEY_SIGN);
    chk("rand_clear_fnd", fnd_serial, 0);
    chk("rand_clear_err", err, 0);
    chk("rand_clear_opr", operator, OP_NONE);
  endtask

  initial begin
    repeat (2) @(negedge sw_clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    // 12 + 34 = 46
    press_num(12);
    press(KEY_ADD);
    press_num(34);
    exp_q.push_back('{12, 34, 0});
    press(KEY_EQ);
    chk("t1_start", calc_start, 1);
    done(46, 1'b0);
    chk("t1_start_low", calc_start, 0);
    chk("t1_fnd", fnd_serial, 46);
    press(KEY_EQ);
    chk("t1_show_hold", fnd_serial, 46);

    // fifth digit dropped
    do_reset();
    press_num(12345);
    chk("t2_limit", fnd_serial, 1234);

    // -5 * 3
    do_reset();
    press(4'd5);
    press(KEY_SIGN);
    chk("t3_neg", fnd_serial, -5);
    press(KEY_MUL);
    press(4'd3);
    exp_q.push_back('{-5, 3, 2});
    press(KEY_EQ);
    done(-15, 1'b0);
    chk("t3_fnd", fnd_serial, -15);

    // -0 loads as 0
    do_reset();
    press(KEY_SIGN);
    chk("t3b_negzero", fnd_serial, 0);

    // 8 / 0 with error, then recover on a digit
    do_reset();
    press(4'd8);
    press(KEY_DIV);
    press(4'd0);
    exp_q.push_back('{8, 0, 3});
    press(KEY_EQ);
    done(0, 1'b1);
    chk("t4_err", err, 1);
    chk("t4_fnd", fnd_serial, ERR_CODE);
    press(4'd7);
    chk("t4_rec_err", err, 0);
    chk("t4_rec_fnd", fnd_serial, 7);

    // timeout, late done ignored
    do_reset();
    press(4'd1);
    press(KEY_ADD);
    press(4'd1);
    exp_q.push_back('{1, 1, 0});
    press(KEY_EQ);
    repeat (63) @(negedge sw_clk);
    chk("t5_before_tmo", err, 0);
    @(negedge sw_clk);
    chk("t5_tmo_err", err, 1);
    repeat (5) @(negedge sw_clk);
    done(99, 1'b0);
    chk("t5_late_err", err, 1);
    chk("t5_late_fnd", fnd_serial, ERR_CODE);
    press(4'd7);
    chk("t5_rec_fnd", fnd_serial, 7);

    // reset mid-CALC
    do_reset();
    press(4'd1);
    press(KEY_ADD);
    press(4'd2);
    exp_q.push_back('{1, 2, 0});
    press(KEY_EQ);
    repeat (3) @(negedge sw_clk);
    do_reset();
    chk_reset_vals("t6_rst");
    done(3, 1'b0);
    chk("t6_late_fnd", fnd_serial, 0);
    press(4'd5);
    chk("t6_entry", fnd_serial, 5);

    // operator key in SHOW
    do_reset();
    press(4'd2);
    press(KEY_ADD);
    press(4'd2);
    exp_q.push_back('{2, 2, 0});
    press(KEY_EQ);
    done(4, 1'b0);
    press(KEY_SUB);
`ifdef CALC_CHAIN_EN
    chk("t7_chain_fnd", fnd_serial, 0);
    press(4'd1);
    exp_q.push_back('{4, 1, 1});
    press(KEY_EQ);
    chk("t7_chain_start", calc_start, 1);
    done(3, 1'b0);
    chk("t7_chain_res", fnd_serial, 3);
`else
    chk("t7_nochain_fnd", fnd_serial, 4);
    press(4'd1);
    chk("t7_nochain_entry", fnd_serial, 1);
    press(KEY_EQ);
    chk("t7_nochain_nostart", calc_start, 0);
`endif

    // randomized rounds
    do_reset();
    repeat (40) rand_round();

    repeat (2) @(negedge sw_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
